// File: rtl/core_dbus_bridge.sv
// core_dbus_bridge: converts the core's single-cycle load/store port into a
// request/grant/response system bus. The core pipeline is held on stall_req
// until the transfer completes. Read data is returned on the cycle the stall
// is released.
//
// Ports:
//   clk, rst_n               core clock, asynchronous active-low reset
//   access_ram_read/write    core load/store requests, held while stalled
//   access_ram_write_width   0 byte, 1 half, 2 word, 3 reserved (misaligned)
//   access_ram_raddr/waddr   load/store byte addresses
//   access_ram_wdata         right-aligned store data
//   access_ram_rdata         aligned 32-bit read word (registered)
//   stall_req                stall to core (combinational only in IDLE)
//   dbus_fault               one-cycle pulse: misaligned store, bus error, timeout
//   bus_req/we/addr/be/wdata registered request channel
//   bus_gnt                  request accepted this cycle
//   bus_rsp_valid/rdata/err  response channel
//
// Build option: define DBUS_TIMEOUT_EN to add a per-phase wait counter that
// aborts a phase after TIMEOUT_CYCLES cycles without progress.
module core_dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        access_ram_read,
  input  logic        access_ram_write,
  input  logic [1:0]  access_ram_write_width,
  input  logic [31:0] access_ram_raddr,
  input  logic [31:0] access_ram_waddr,
  input  logic [31:0] access_ram_wdata,
  output logic [31:0] access_ram_rdata,
  output logic        stall_req,
  output logic        dbus_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Latched read intent; the core's inputs are not trusted after IDLE.
  logic        rd_pend;
  logic        rd_pend_next;
  logic [29:0] raddr_word;
  logic [29:0] raddr_word_next;

  logic        bus_req_next;
  logic        bus_we_next;
  logic [31:0] bus_addr_next;
  logic [3:0]  bus_be_next;
  logic [31:0] bus_wdata_next;
  logic [31:0] rdata_next;
  logic        fault_next;

  logic        wr_misaligned;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        timeout_hit;

  // Load lane selection happens in the core; only the word address matters.
  logic unused_raddr_lsb;
  assign unused_raddr_lsb = ^access_ram_raddr[1:0];

  // Store decode from the live core inputs, consumed only in IDLE.
  always_comb begin
    wr_misaligned = 1'b0;
    wr_be         = 4'b0000;
    wr_data       = access_ram_wdata;
    case (access_ram_write_width)
      2'd0: begin
        wr_be   = 4'(4'b0001 << access_ram_waddr[1:0]);
        wr_data = {4{access_ram_wdata[7:0]}};
      end
      2'd1: begin
        wr_misaligned = access_ram_waddr[0];
        wr_be         = access_ram_waddr[1] ? 4'b1100 : 4'b0011;
        wr_data       = {2{access_ram_wdata[15:0]}};
      end
      2'd2: begin
        wr_misaligned = |access_ram_waddr[1:0];
        wr_be         = 4'b1111;
      end
      default: wr_misaligned = 1'b1;
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             progress;

  always_comb begin
    in_wait  = (state == WR_REQ) || (state == WR_WAIT) ||
               (state == RD_REQ) || (state == RD_WAIT);
    progress = (((state == WR_REQ) || (state == RD_REQ)) && bus_gnt) ||
               (((state == WR_WAIT) || (state == RD_WAIT)) && bus_rsp_valid);
    timeout_hit = in_wait && !progress &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Cycles spent in the current phase; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  // Timeout logic not built; parameter kept for a uniform interface.
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (access_ram_write) begin
          if (!wr_misaligned) begin
            state_next = WR_REQ;
          end else if (access_ram_read) begin
            state_next = RD_REQ;
          end else begin
            state_next = DONE;
          end
        end else if (access_ram_read) begin
          state_next = RD_REQ;
        end
      end
      WR_REQ:  if (bus_gnt) state_next = WR_WAIT;
      WR_WAIT: if (bus_rsp_valid) state_next = rd_pend ? RD_REQ : DONE;
      RD_REQ:  if (bus_gnt) state_next = RD_WAIT;
      RD_WAIT: if (bus_rsp_valid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = DONE;
    end
  end

  // Output logic: stall decode plus next values of the registered outputs.
  always_comb begin
    stall_req       = 1'b0;
    rd_pend_next    = rd_pend;
    raddr_word_next = raddr_word;
    bus_req_next    = (state_next == WR_REQ) || (state_next == RD_REQ);
    bus_we_next     = bus_we;
    bus_addr_next   = bus_addr;
    bus_be_next     = bus_be;
    bus_wdata_next  = bus_wdata;
    rdata_next      = access_ram_rdata;
    fault_next      = 1'b0;

    case (state)
      IDLE: begin
        stall_req = access_ram_read | access_ram_write;
        if (access_ram_read | access_ram_write) begin
          rd_pend_next    = access_ram_read;
          raddr_word_next = access_ram_raddr[31:2];
        end
        if (access_ram_write) begin
          if (wr_misaligned) begin
            fault_next = 1'b1;
          end else begin
            bus_we_next    = 1'b1;
            bus_addr_next  = {access_ram_waddr[31:2], 2'b00};
            bus_be_next    = wr_be;
            bus_wdata_next = wr_data;
          end
        end
      end
      WR_REQ, RD_REQ: stall_req = 1'b1;
      WR_WAIT: begin
        stall_req = 1'b1;
        if (bus_rsp_valid && bus_err) begin
          fault_next = 1'b1;
        end
      end
      RD_WAIT: begin
        stall_req = 1'b1;
        if (bus_rsp_valid) begin
          rdata_next = bus_err ? 32'h0 : bus_rdata;
          fault_next = bus_err;
        end
      end
      DONE:    stall_req = 1'b0;
      default: stall_req = 1'b0;
    endcase

    // Entering the read phase: present the latched load address.
    if ((state_next == RD_REQ) && (state != RD_REQ)) begin
      bus_we_next    = 1'b0;
      bus_addr_next  = {raddr_word_next, 2'b00};
      bus_be_next    = 4'b1111;
      bus_wdata_next = 32'h0;
    end

    if (timeout_hit) begin
      rdata_next = 32'h0;
      fault_next = 1'b1;
    end
  end

  // Registered outputs and latched request context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend          <= 1'b0;
      raddr_word       <= '0;
      bus_req          <= 1'b0;
      bus_we           <= 1'b0;
      bus_addr         <= 32'h0;
      bus_be           <= 4'b0000;
      bus_wdata        <= 32'h0;
      access_ram_rdata <= 32'h0;
      dbus_fault       <= 1'b0;
    end else begin
      rd_pend          <= rd_pend_next;
      raddr_word       <= raddr_word_next;
      bus_req          <= bus_req_next;
      bus_we           <= bus_we_next;
      bus_addr         <= bus_addr_next;
      bus_be           <= bus_be_next;
      bus_wdata        <= bus_wdata_next;
      access_ram_rdata <= rdata_next;
      dbus_fault       <= fault_next;
    end
  end

endmodule

// File: tb/tb_core_dbus_bridge.sv
// Self-checking bench for core_dbus_bridge: directed core accesses, a bus
// slave that answers from a queue of expected transactions, and stall/fault/
// read-data checks per access.
module tb_core_dbus_bridge;

  logic        clk;
  logic        rst_n;
  logic        access_ram_read;
  logic        access_ram_write;
  logic [1:0]  access_ram_write_width;
  logic [31:0] access_ram_raddr;
  logic [31:0] access_ram_waddr;
  logic [31:0] access_ram_wdata;
  logic [31:0] access_ram_rdata;
  logic        stall_req;
  logic        dbus_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  core_dbus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .access_ram_read        (access_ram_read),
    .access_ram_write       (access_ram_write),
    .access_ram_write_width (access_ram_write_width),
    .access_ram_raddr       (access_ram_raddr),
    .access_ram_waddr       (access_ram_waddr),
    .access_ram_wdata       (access_ram_wdata),
    .access_ram_rdata       (access_ram_rdata),
    .stall_req              (stall_req),
    .dbus_fault             (dbus_fault),
    .bus_req                (bus_req),
    .bus_we                 (bus_we),
    .bus_addr               (bus_addr),
    .bus_be                 (bus_be),
    .bus_wdata              (bus_wdata),
    .bus_gnt                (bus_gnt),
    .bus_rsp_valid          (bus_rsp_valid),
    .bus_rdata              (bus_rdata),
    .bus_err                (bus_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  int   gnt_delay = 0;
  logic gnt_block = 1'b0;
  logic rsp_hold  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err);
    txn_t t;
    t.we = we; t.addr = addr; t.be = be; t.wdata = wdata; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  // Bus slave: checks each request against the queue head, grants after
  // gnt_delay cycles, answers on the cycle after the grant.
  initial begin : slave
    txn_t cur;
    int   wait_cnt;
    logic rsp_pend;
    wait_cnt = 0;
    rsp_pend = 1'b0;
    bus_gnt = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus_gnt = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
      if (!rst_n) begin
        rsp_pend = 1'b0;
        wait_cnt = 0;
      end else if (rsp_pend) begin
        if (!rsp_hold) begin
          bus_rsp_valid = 1'b1;
          bus_rdata     = cur.rdata;
          bus_err       = cur.err;
          rsp_pend      = 1'b0;
        end
      end else if (bus_req && !gnt_block) begin
        if (exp_q.size() == 0) begin
          check("req_without_expected_txn", 32'(bus_req), 32'h0);
        end else begin
          cur = exp_q[0];
          check("bus_we",    32'(bus_we), 32'(cur.we));
          check("bus_addr",  bus_addr, cur.addr);
          check("bus_be",    32'(bus_be), 32'(cur.be));
          check("bus_wdata", bus_wdata, cur.wdata);
          if (wait_cnt == gnt_delay) begin
            bus_gnt  = 1'b1;
            void'(exp_q.pop_front());
            rsp_pend = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // One core access: drive, count stall and fault cycles up to release.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [1:0] width, input logic [31:0] raddr,
                           input logic [31:0] waddr, input logic [31:0] wdata,
                           input int exp_stalls, input int exp_faults,
                           input logic [31:0] exp_rdata);
    int   stalls;
    int   faults;
    logic done;
    access_ram_read        = rd;
    access_ram_write       = wr;
    access_ram_write_width = width;
    access_ram_raddr       = raddr;
    access_ram_waddr       = waddr;
    access_ram_wdata       = wdata;
    stalls = 0;
    faults = 0;
    done   = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      #2;
      if (stall_req)  stalls++;
      if (dbus_fault) faults++;
      if (!stall_req) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_released"}, 32'(done), 32'h1);
    if (rd) check({tag, "_rdata"}, access_ram_rdata, exp_rdata);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_fault_pulses"}, 32'(faults), 32'(exp_faults));
    access_ram_read  = 1'b0;
    access_ram_write = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_idle_stall"}, 32'(stall_req), 32'h0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0;
    access_ram_read = 1'b0; access_ram_write = 1'b0; access_ram_write_width = 2'd0;
    access_ram_raddr = 32'h0; access_ram_waddr = 32'h0; access_ram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall_req", 32'(stall_req), 32'h0);
    check("rst_bus_req",   32'(bus_req),   32'h0);
    check("rst_bus_we",    32'(bus_we),    32'h0);
    check("rst_fault",     32'(dbus_fault), 32'h0);
    check("rst_bus_addr",  bus_addr,       32'h0);
    check("rst_bus_be",    32'(bus_be),    32'h0);
    check("rst_bus_wdata", bus_wdata,      32'h0);
    check("rst_rdata",     access_ram_rdata, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load from an unaligned byte address: word-aligned, all lanes.
    exp_q.push_back(mk(1'b0, 32'h2000_0004, 4'b1111, 32'h0, 32'hA1B2C3D4, 1'b0));
    do_access("load", 1'b1, 1'b0, 2'd0, 32'h2000_0006, 32'h0, 32'h0, 3, 0, 32'hA1B2C3D4);

    // Byte store to lane 3.
    exp_q.push_back(mk(1'b1, 32'h0100_0000, 4'b1000, 32'h5A5A5A5A, 32'h0, 1'b0));
    do_access("st_byte", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0100_0003, 32'h0000_005A, 3, 0, 32'h0);

    // Half store to upper half.
    exp_q.push_back(mk(1'b1, 32'h0000_0040, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0));
    do_access("st_half", 1'b0, 1'b1, 2'd1, 32'h0, 32'h0000_0042, 32'h0000_BEEF, 3, 0, 32'h0);

    // Read answered with bus error: data forced to zero, one fault.
    exp_q.push_back(mk(1'b0, 32'h0000_0200, 4'b1111, 32'h0, 32'hFFFF_FFFF, 1'b1));
    do_access("ld_err", 1'b1, 1'b0, 2'd0, 32'h0000_0201, 32'h0, 32'h0, 3, 1, 32'h0);

    // Grant delayed 4 cycles; slave checks fields stay stable while waiting.
    gnt_delay = 4;
    exp_q.push_back(mk(1'b0, 32'h0000_0300, 4'b1111, 32'h0, 32'h11223344, 1'b0));
    do_access("ld_gnt_delay", 1'b1, 1'b0, 2'd0, 32'h0000_0300, 32'h0, 32'h0, 7, 0, 32'h11223344);
    gnt_delay = 0;

    // Simultaneous store and load: write first, one continuous stall.
    exp_q.push_back(mk(1'b1, 32'h0000_0040, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h0000_0080, 4'b1111, 32'h0, 32'h55667788, 1'b0));
    do_access("st_ld", 1'b1, 1'b1, 2'd2, 32'h0000_0080, 32'h0000_0040, 32'hCAFEF00D, 5, 0, 32'h55667788);

    // Misaligned half store: nothing on the bus.
    do_access("st_misalign", 1'b0, 1'b1, 2'd1, 32'h0, 32'h0000_0041, 32'h0000_1234, 1, 1, 32'h0);

    // Reserved width plus load: store dropped, load still served.
    exp_q.push_back(mk(1'b0, 32'h0000_0084, 4'b1111, 32'h0, 32'h0BADBEEF, 1'b0));
    do_access("st_w3_ld", 1'b1, 1'b1, 2'd3, 32'h0000_0084, 32'h0000_0000, 32'h0, 3, 1, 32'h0BADBEEF);

`ifdef DBUS_TIMEOUT_EN
    // No grant: abort after 8 request cycles.
    gnt_block = 1'b1;
    do_access("ld_timeout", 1'b1, 1'b0, 2'd0, 32'h0000_0010, 32'h0, 32'h0, 9, 1, 32'h0);
    gnt_block = 1'b0;
    check("timeout_bus_req_low", 32'(bus_req), 32'h0);
`endif

    exp_q.push_back(mk(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 32'h600DF00D, 1'b0));
    do_access("ld_pre_rst", 1'b1, 1'b0, 2'd0, 32'h0000_2000, 32'h0, 32'h0, 3, 0, 32'h600DF00D);

    // Reset during RD_WAIT with the response withheld.
    rsp_hold = 1'b1;
    exp_q.push_back(mk(1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'h77777777, 1'b0));
    access_ram_read  = 1'b1;
    access_ram_raddr = 32'h0000_0500;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_stall_in_wait", 32'(stall_req), 32'h1);
    #4;
    access_ram_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_stall_req", 32'(stall_req), 32'h0);
    check("arst_bus_req",   32'(bus_req),   32'h0);
    check("arst_bus_we",    32'(bus_we),    32'h0);
    check("arst_fault",     32'(dbus_fault), 32'h0);
    check("arst_bus_addr",  bus_addr,       32'h0);
    check("arst_bus_be",    32'(bus_be),    32'h0);
    check("arst_bus_wdata", bus_wdata,      32'h0);
    check("arst_rdata",     access_ram_rdata, 32'h0);
    check("arst_queue",     32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #5;
    rst_n    = 1'b1;
    rsp_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_bus_req", 32'(bus_req),   32'h0);
    check("post_rst_stall",   32'(stall_req), 32'h0);
    check("post_rst_rdata",   access_ram_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/core_dbus_bridge.md
# core_dbus_bridge

Data-side bridge directly downstream of the RISC-V core's load/store port. It converts the core's single-cycle access interface (read/write enables, separate read/write addresses, write width) into a request/grant/response system bus. It holds the pipeline through the core's `stall_req` input while a transfer is outstanding, and returns read data on the cycle the stall is released.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles per bus phase; used only when timeout is compiled in; must be ≥1.
- `clk` in 1: core clock.
- `rst_n` in 1: reset; one clock, asynchronous assert, active-low.
- `access_ram_read` in 1: core load request, held until stall releases.
- `access_ram_write` in 1: core store request, held until stall releases.
- `access_ram_write_width` in 2: 0 = byte, 1 = half, 2 = word; 3 = reserved, treated as misaligned.
- `access_ram_raddr` in 32: load byte address.
- `access_ram_waddr` in 32: store byte address.
- `access_ram_wdata` in 32: store data, right-aligned.
- `access_ram_rdata` out 32: aligned 32-bit word read; the core extracts lanes.
- `stall_req` out 1: to the core's stall request input.
- `dbus_fault` out 1: one-cycle pulse on misaligned store, bus error, or timeout.
- `bus_req` out 1: request valid.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, bits [1:0] = 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated write data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rsp_valid` in 1: response valid.
- `bus_rdata` in 32: response data.
- `bus_err` in 1: response error, qualified by `bus_rsp_valid`.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- **IDLE**
  - `stall_req` = `access_ram_read | access_ram_write`. This is the only combinational path.
  - On any access: latch addresses, data, width and both enables.
  - Go to WR_REQ if write, else RD_REQ.
- **WR_REQ / RD_REQ**
  - Hold `bus_req`=1 and the bus fields stable until `bus_gnt`.
  - On grant, go to the matching *_WAIT state.
- **WR_WAIT**
  - On `bus_rsp_valid`, go to RD_REQ if the read was also latched, else DONE.
- **RD_WAIT**
  - On `bus_rsp_valid`, capture `bus_rdata` into the read-data register and go to DONE.
- **DONE**
  - `stall_req`=0.
  - `access_ram_rdata` holds the register.
  - Go to IDLE unconditionally. A back-to-back access is sampled in IDLE on the next cycle.
- **Simultaneous read and write**: the write is served first, then the read, all under one continuous stall.
- **Byte enables**
  - Byte: `1<<a[1:0]`.
  - Half: `0011` or `1100` by `a[1]`.
  - Word: `1111`.
  - Reads always use `1111`.
- **Write data**
  - Byte: replicated ×4.
  - Half: replicated ×2.
  - Word: as is.
- **Misaligned store** (half with `a[0]`=1, word with `a[1:0]`≠0, or width 3):
  - Not issued on the bus.
  - Go directly to RD_REQ/DONE.
  - Pulse `dbus_fault`.
- Loads are never misaligned here; the core extracts lanes from the aligned word.
- **`bus_err` on a response**
  - Read data is forced to 0 and `dbus_fault` pulses.
  - Otherwise completes as normal.
- While stalled, the core's access outputs are required stable. The bridge uses only the latched copies after IDLE.

## Timing
- **Reset values**
  - `stall_req`, `bus_req`, `bus_we`, `dbus_fault` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `access_ram_rdata` = 0.
  - State = IDLE.
- Asserting `rst_n` mid-transfer drops `bus_req` immediately and abandons any response.
- All bus outputs are registered; `bus_req` is never combinational from core inputs.
- **Minimum read** (grant in the first REQ cycle, response on the next cycle):
  - Stall cycles c0 (IDLE), c1 (RD_REQ), c2 (RD_WAIT).
  - c3 is DONE: `stall_req`=0 and data valid.
- **Write**: same 3 stall cycles.
- **Read + write**: 5 stall cycles minimum.
- **Misaligned store**: 1 stall cycle (IDLE), then DONE.
- `bus_rsp_valid` is ignored in REQ states and in IDLE.

## Configuration
- **`DBUS_TIMEOUT_EN` defined**
  - A wait counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on every state change and counts in REQ and WAIT states.
  - On reaching `TIMEOUT_CYCLES`: drop `bus_req`, force read data to 0, pulse `dbus_fault`, and go to DONE, skipping any pending read phase.
  - A late response after the timeout is ignored.
- **Undefined**: no counter; the bridge waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Test plan
- Load `0x2000_0006`, grant immediately, response on the next cycle with `0xA1B2C3D4`:
  - `bus_addr`=`0x2000_0004`, `bus_be`=`1111`.
  - Stall for 3 cycles; `access_ram_rdata`=`0xA1B2C3D4` in the release cycle.
- Store byte `0x5A` to `0x100_0003`:
  - `bus_be`=`1000`, `bus_wdata`=`0x5A5A5A5A`, `bus_we`=1.
- Grant delayed 4 cycles:
  - `bus_req` and fields held stable.
  - Stall = 7 cycles.
- Simultaneous store of word `0xCAFEF00D` to `0x40` and load from `0x80`:
  - Write issued before read.
  - `stall_req` continuous until DONE.
- Store half to `0x41`:
  - No `bus_req`; `dbus_fault` pulses once; stall is 1 cycle.
- With `DBUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no grant:
  - Abort after 8 wait cycles.
  - `dbus_fault`=1, rdata=0, state returns to IDLE.
  - Also pulse `rst_n` low mid-RD_WAIT and check that all outputs are 0 asynchronously.
